serial_rx: RTL and testbench

//   Memory-mapped UART receiver: the input direction of the serial console (the transmit side is Serial).

---
 rtl/serial_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/serial_rx.sv | 195 +++++++++++++++++++
 tb/tb_serial_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial console peripherals: register offsets,
// receiver state encoding and STATUS register bit positions.
package serial_pkg;

  // Byte offsets inside the device window; only bit 2 is decoded.
  localparam logic [31:0] REG_DATA   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;

  // Receiver frame state.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // STATUS register bit positions.
  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_FRAME_ERR = 2;
  localparam int ST_OVERFLOW  = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop of an empty FIFO
// is ignored, so empty+push+pop leaves the pushed entry in place.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify the requests against occupancy and advance pointers and count.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; entries are only observable after
    // a push, so clearing them would just cost a reset fan-out per bit.
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Memory-mapped 8N1 UART receiver. Oversamples the synchronized line,
// assembles bytes LSB first, queues them in a FIFO and exposes DATA and
// STATUS registers to CPU polling with a one-clock registered read.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        rx,
  input  logic        sel,
  input  logic        re,
  input  logic [31:0] addr,
  output logic [31:0] dout
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PHASE_HALF = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(OVERSAMPLE - 1);

  // Line synchronizer and baud tick divider.
  logic             rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  // Receiver FSM state.
  rx_state_t        state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             stop_ok, frame_err_set;

  // Sticky flags and read port.
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      dout_q, dout_d;
  logic             access, data_rd, stat_rd;

  // FIFO interface.
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic [CNT_W-1:0] unused_fifo_count;
  logic             unused_addr;

  assign tick        = (div_cnt_q == DIV_LAST);
  assign access      = sel & re;
  assign data_rd     = access & (addr[2] == REG_DATA[2]);
  assign stat_rd     = access & (addr[2] == REG_STATUS[2]);
  assign fifo_pop    = data_rd & ~fifo_empty;
  assign dout        = dout_q;
  assign unused_addr = ^{addr[31:3], addr[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (clrn),
    .push    (push_q),
    .pop     (fifo_pop),
    .wr_data (shift_q),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  // Free-running divider: wraps at DIV-1 and flags that cycle as a tick.
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Frame FSM next state; only moves on ticks, decisions use the synced line.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    stop_ok       = 1'b0;
    frame_err_set = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_sync_q) begin
            state_d = START;
            phase_d = '0;
          end
        end
        START: begin
          if (phase_q == PHASE_HALF) begin
            phase_d = '0;
            if (!rx_sync_q) begin
              state_d   = DATA;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        DATA: begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        STOP: begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            if (rx_sync_q) begin
              stop_ok = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_set = 1'b1;
              state_d       = BREAK;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_sync_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky flags and registered read mux; a set in the clearing cycle wins.
  always_comb begin
    push_d      = stop_ok;
    frame_err_d = frame_err_set | (frame_err_q & ~stat_rd);
    overflow_d  = (push_q & fifo_full & ~fifo_pop) | (overflow_q & ~stat_rd);
    dout_d      = dout_q;
    if (data_rd) begin
      dout_d = fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_rd_data};
    end else if (stat_rd) begin
      dout_d               = '0;
      dout_d[ST_NONEMPTY]  = ~fifo_empty;
      dout_d[ST_FULL]      = fifo_full;
      dout_d[ST_FRAME_ERR] = frame_err_q;
      dout_d[ST_OVERFLOW]  = overflow_q;
    end
  end

  // Synchronizer, divider, FSM, flags and read data registers.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      div_cnt_q   <= '0;
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      dout_q      <= '0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: 64 clocks per bit, 4-entry FIFO.
// All stimulus and sampling happen on the falling clock edge.
module tb_serial_rx;

  localparam int CLK_HZ     = 640;
  localparam int BAUD       = 10;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 64;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;

  logic        clock = 1'b0;
  logic        clrn  = 1'b0;
  logic        rx    = 1'b1;
  logic        sel   = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] dout;

  int n_tests  = 0;
  int n_failed = 0;

  serial_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock (clock),
    .clrn  (clrn),
    .rx    (rx),
    .sel   (sel),
    .re    (re),
    .addr  (addr),
    .dout  (dout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One 8N1 frame, LSB first, followed by 16 idle clocks.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1,
                           input int stop_clks = BIT_CLKS);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    rx = stop_bit;
    idle(stop_clks);
    rx = 1'b1;
    idle(16);
  endtask

  // Access strobe for one clock starting at a falling edge; dout is taken at
  // the next falling edge, after the access edge has updated it.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sel  = 1'b1;
    re   = 1'b1;
    addr = a;
    @(negedge clock);
    sel  = 1'b0;
    re   = 1'b0;
    addr = '0;
    d    = dout;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        seen;

    // Reset state.
    idle(3);
    check("reset_dout", dout, 32'h0);
    clrn = 1'b1;
    idle(8);
    read_check("reset_status", A_STATUS, 32'h0);
    read_check("reset_data", A_DATA, 32'h0);

    // 1: single frame.
    send_byte(8'hA5);
    read_check("t1_data", A_DATA, 32'h1A5);
    read_check("t1_data_empty", A_DATA, 32'h0);

    // 2: short low glitch is rejected at the start-bit resample.
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(200);
    read_check("t2_status", A_STATUS, 32'h0);
    read_check("t2_data", A_DATA, 32'h0);

    // 3: framing error with a held-low stop bit.
    send_byte(8'h3C, 1'b0, 200);
    read_check("t3_status_err", A_STATUS, 32'h4);
    read_check("t3_status_clr", A_STATUS, 32'h0);
    read_check("t3_data_empty", A_DATA, 32'h0);

    // 4: overflow on the fifth byte.
    for (int i = 1; i <= 5; i++) begin
      d = i;
      send_byte(d[7:0]);
    end
    read_check("t4_status", A_STATUS, 32'hB);
    read_check("t4_data0", A_DATA, 32'h101);
    read_check("t4_data1", A_DATA, 32'h102);
    read_check("t4_data2", A_DATA, 32'h103);
    read_check("t4_data3", A_DATA, 32'h104);
    read_check("t4_data_empty", A_DATA, 32'h0);

    // 5: pop aligned with a push into a full FIFO.
    for (int i = 1; i <= 4; i++) begin
      d = i;
      send_byte(d[7:0]);
    end
    read_check("t5_status_full", A_STATUS, 32'h3);
    seen = 1'b0;
    fork
      send_byte(8'h55);
      begin
        for (int k = 0; k < 2000 && !seen; k++) begin
          if (dut.push_q) seen = 1'b1;
          else @(negedge clock);
        end
        check("t5_push_seen", {31'b0, seen}, 32'h1);
        if (seen) begin
          bus_read(A_DATA, d);
          check("t5_aligned_data", d, 32'h101);
        end
      end
    join
    read_check("t5_status", A_STATUS, 32'h3);
    read_check("t5_data1", A_DATA, 32'h102);
    read_check("t5_data2", A_DATA, 32'h103);
    read_check("t5_data3", A_DATA, 32'h104);
    read_check("t5_data4", A_DATA, 32'h155);
    read_check("t5_data_empty", A_DATA, 32'h0);

    // 6: reset in the middle of data bit 4 with a byte already queued.
    send_byte(8'h12);
    read_check("t6_status_pre", A_STATUS, 32'h1);
    rx = 1'b0;
    idle(BIT_CLKS + 4 * BIT_CLKS + BIT_CLKS / 2);
    clrn = 1'b0;
    rx   = 1'b1;
    idle(3);
    check("t6_reset_dout", dout, 32'h0);
    clrn = 1'b1;
    idle(40);
    read_check("t6_status", A_STATUS, 32'h0);
    read_check("t6_data_empty", A_DATA, 32'h0);
    send_byte(8'h7E);
    read_check("t6_data", A_DATA, 32'h17E);
    read_check("t6_status_post", A_STATUS, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
